// File: rtl/pri_encoder_rr.sv
// pri_encoder_rr
// Registered N-to-log2(N) priority encoder with a valid/ready output handshake.
// Each accepted cycle captures one grant from the request vector. The search
// is either fixed priority, where bit 0 is highest, or round-robin from a
// rotating pointer. An empty request vector is reported as out_valid = 0
// instead of a default code.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        [N-1:0] request vector, sampled on load cycles only
//   mode       0 = fixed priority, 1 = round-robin
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a valid grant
//   out_idx    [W-1:0] encoded index of the granted request
//   out_multi  more than one req bit was set when out_idx was captured
//
// Build option:
//   PRI_ENC_MULTI_EN  When defined, out_multi is computed and registered with
//                     out_idx. When undefined, out_multi is tied to 0 and the
//                     multiple-request detection is not compiled.
//
// N must be a power of two and at least 2. Round-robin index arithmetic
// relies on W-bit wraparound being the same as modulo N.

module pri_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi
);

    logic [W-1:0]   ptr;
    logic           load;
    logic           any_req;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [W-1:0]   fixed_grant;
    logic [W-1:0]   rot_offset;
    logic [W-1:0]   grant;

    // Index of the lowest set bit. Returns 0 when no bit is set; callers
    // qualify the result with any_req.
    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] idx;
        logic         found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i] && !found) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign load    = !out_valid || out_ready;
    assign any_req = |req;

    // Round-robin search: rotate req right by ptr so that the pointer
    // position becomes bit 0. Then take the lowest set bit and add ptr back.
    // The W-bit sum wraps modulo N.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        fixed_grant = lowest_set(req);
        rot_offset  = lowest_set(req_rot);
        grant       = mode ? W'(ptr + rot_offset) : fixed_grant;
    end

`ifdef PRI_ENC_MULTI_EN
    logic req_multi;

    // Clearing the lowest set bit leaves a nonzero value exactly when at
    // least two bits were set. This is the same as popcount(req) > 1.
    assign req_multi = (req & (req - N'(1))) != '0;
`else
    assign out_multi = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= '0;
`ifdef PRI_ENC_MULTI_EN
            out_multi <= 1'b0;
`endif
        end else if (load) begin
            out_valid <= any_req;
            if (any_req) begin
                out_idx <= grant;
`ifdef PRI_ENC_MULTI_EN
                out_multi <= req_multi;
`endif
                // The pointer only moves on a round-robin grant. It is left
                // alone in fixed mode, so it is still in place when
                // round-robin mode resumes.
                if (mode) begin
                    ptr <= W'(grant + W'(1));
                end
            end else begin
                out_idx <= '0;
`ifdef PRI_ENC_MULTI_EN
                out_multi <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pri_encoder_rr.sv
module tb_pri_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_multi;

    pri_encoder_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_multi (out_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit multi;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    // Reference state: what the outputs should show, plus the search pointer.
    bit m_valid = 0;
    int m_ptr   = 0;
    bit exp_valid_now = 0;

    // Walk the indices upward from the starting point, wrapping modulo N.
    function automatic int model_grant(input logic [N-1:0] r, input bit md, input int p);
        int start;
        int j;
        start = md ? p : 0;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic bit model_multi(input logic [N-1:0] r);
`ifdef PRI_ENC_MULTI_EN
        return $countones(r) > 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input bit r, input logic [N-1:0] rq, input bit md, input bit rdy);
        int g;
        exp_t e;
        @(posedge clk);
        #2;
        rst       = r;
        req       = rq;
        mode      = md;
        out_ready = rdy;
        exp_valid_now = m_valid;
        if (r) begin
            m_valid = 0;
            m_ptr   = 0;
            sbq.delete();
        end else if (!m_valid || rdy) begin
            if (rq != 0) begin
                g       = model_grant(rq, md, m_ptr);
                e.idx   = g;
                e.multi = model_multi(rq);
                sbq.push_back(e);
                m_valid = 1;
                if (md) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Monitor: compares at the negedge, while the outputs are stable.
    always begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (out_valid !== exp_valid_now) begin
                errors++;
                $display("FAIL valid: got %0b expected %0b at %0t", out_valid, exp_valid_now, $time);
            end
            if (out_valid !== 1'b1) begin
                checks++;
                if (out_idx !== '0 || out_multi !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got idx=%0d multi=%0b expected idx=0 multi=0 at %0t",
                             out_idx, out_multi, $time);
                end
            end else if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got idx=%0d with no expected grant queued at %0t",
                         out_idx, $time);
            end else if (out_ready) begin
                e = sbq.pop_front();
                checks++;
                if (out_idx !== W'(e.idx) || out_multi !== e.multi) begin
                    errors++;
                    $display("FAIL accept: got idx=%0d multi=%0b expected idx=%0d multi=%0b at %0t",
                             out_idx, out_multi, e.idx, e.multi, $time);
                end
            end else begin
                // While stalled, the displayed grant must stay equal to the
                // oldest grant that has not been accepted yet.
                checks++;
                if (out_idx !== W'(sbq[0].idx) || out_multi !== sbq[0].multi) begin
                    errors++;
                    $display("FAIL stall_hold: got idx=%0d multi=%0b expected idx=%0d multi=%0b at %0t",
                             out_idx, out_multi, sbq[0].idx, sbq[0].multi, $time);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        int sel;
        rst = 1'b1;
        req = '0;
        mode = 1'b0;
        out_ready = 1'b1;

        step(1, 8'h00, 0, 1);
        step(1, 8'h00, 0, 1);

        // Fixed priority: single request, then an idle cycle.
        step(0, 8'b0000_0100, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Fixed priority with two requests set.
        step(0, 8'b1001_0000, 0, 1);
        step(0, 8'h00, 0, 1);

        // Round-robin over a held request; expected order is 0, 1, 7, 0.
        for (int i = 0; i < 4; i++) step(0, 8'b1000_0011, 1, 1);
        step(0, 8'h00, 1, 1);

        // Stall: the grant of 5 is held, then accepted, then the next grant is 0.
        step(0, 8'b0010_0000, 0, 0);
        step(0, 8'b0010_0000, 0, 0);
        step(0, 8'b0010_0000, 0, 0);
        step(0, 8'b0000_0001, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Round-robin grant of 6 is stalled, then reset clears it and the pointer.
        step(0, 8'b0100_0000, 1, 0);
        step(0, 8'b0100_0000, 1, 0);
        step(1, 8'b0100_0000, 1, 0);
        step(0, 8'hFF, 1, 1);
        step(0, 8'h00, 1, 1);

        // Switch modes with the pointer at 3: expect 1 in fixed mode, then 3 in round-robin.
        step(0, 8'b0000_0100, 1, 1);
        step(0, 8'b0000_1010, 0, 1);
        step(0, 8'b0000_1010, 1, 1);
        step(0, 8'h00, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) rq = '0;
            else if (sel < 5) rq = N'(1) << $urandom_range(0, N - 1);
            else rq = N'($urandom);
            step(($urandom_range(0, 49) == 0), rq, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7));
        end

        // Drain the outputs, then confirm that every expected grant was accepted.
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
        @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d grants left unaccepted, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
